// File: rtl/sdram_port_arbiter.sv
// Shares one 8-bit SDRAM port between buffered loader writes and cassette reads.
// Define SDRAM_ARB_STATS_EN to add saturating write/read/starvation counters.
module sdram_port_arbiter #(
  parameter int unsigned AW          = 25,
  parameter int unsigned WFIFO_DEPTH = 4,
  parameter int unsigned MEM_LAT     = 6,
  parameter int unsigned STARVE_MAX  = 3
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ld_wr,
  input  logic [AW-1:0] ld_addr,
  input  logic [7:0]    ld_data,
  output logic          ld_busy,
  output logic          ld_overflow,
  input  logic          cas_req,
  input  logic [AW-1:0] cas_addr,
  output logic          cas_ack,
  output logic [7:0]    cas_data,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_din,
  output logic          mem_we,
  output logic          mem_rd,
  input  logic [7:0]    mem_dout,
  input  logic          mem_ready
`ifdef SDRAM_ARB_STATS_EN
  ,
  output logic [15:0]   stat_wr_cnt,
  output logic [15:0]   stat_rd_cnt,
  output logic [7:0]    stat_starve_cnt
`endif
);

  localparam int unsigned PW = $clog2(WFIFO_DEPTH) + 1;
  localparam int unsigned IW = PW - 1;
  localparam int unsigned LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e          state_q, state_d;
  logic            op_wr_q, op_wr_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [7:0]      din_q, din_d;
  logic [LW-1:0]   lat_q, lat_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic            ovf_q, ovf_d;
  logic [7:0]      cas_data_q, cas_data_d;
  logic [AW+7:0]   fifo_q [WFIFO_DEPTH];
  logic [AW+7:0]   fifo_d [WFIFO_DEPTH];
  logic            fifo_empty, fifo_full, pop, push;
`ifdef SDRAM_ARB_STATS_EN
  logic [15:0]     stat_wr_q, stat_wr_d, stat_rd_q, stat_rd_d;
  logic [7:0]      stat_starve_q, stat_starve_d;
`endif

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[PW-1] != rptr_q[PW-1]) && (wptr_q[IW-1:0] == rptr_q[IW-1:0]);

  always_comb begin
    state_d    = state_q;
    op_wr_d    = op_wr_q;
    addr_d     = addr_q;
    din_d      = din_q;
    lat_d      = lat_q;
    starve_d   = starve_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    ovf_d      = ovf_q;
    cas_data_d = cas_data_q;
    fifo_d     = fifo_q;
    pop        = 1'b0;
    push       = 1'b0;
    mem_we     = 1'b0;
    mem_rd     = 1'b0;
    cas_ack    = 1'b0;
`ifdef SDRAM_ARB_STATS_EN
    stat_wr_d     = stat_wr_q;
    stat_rd_d     = stat_rd_q;
    stat_starve_d = stat_starve_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty && !(cas_req && starve_q == SW'(STARVE_MAX))) begin
          op_wr_d           = 1'b1;
          {addr_d, din_d}   = fifo_q[rptr_q[IW-1:0]];
          pop               = 1'b1;
          state_d           = StIssue;
        end else if (cas_req) begin
          op_wr_d = 1'b0;
          addr_d  = cas_addr;
          din_d   = 8'h00;
          state_d = StIssue;
`ifdef SDRAM_ARB_STATS_EN
          if (!fifo_empty && stat_starve_q != 8'hff) stat_starve_d = stat_starve_q + 8'd1;
`endif
        end
      end
      StIssue: begin
        if (mem_ready) begin
          mem_we  = op_wr_q;
          mem_rd  = !op_wr_q;
          lat_d   = LW'(MEM_LAT - 1);
          state_d = StWait;
        end
      end
      StWait: begin
        if (lat_q == '0) state_d = StDone;
        else             lat_d   = lat_q - LW'(1);
      end
      StDone: begin
        state_d = StIdle;
        if (!op_wr_q) begin
          cas_ack    = 1'b1;
          cas_data_d = mem_dout;
          starve_d   = '0;
`ifdef SDRAM_ARB_STATS_EN
          if (stat_rd_q != 16'hffff) stat_rd_d = stat_rd_q + 16'd1;
`endif
        end else begin
          if (!cas_req)                          starve_d = '0;
          else if (starve_q != SW'(STARVE_MAX))  starve_d = starve_q + SW'(1);
`ifdef SDRAM_ARB_STATS_EN
          if (stat_wr_q != 16'hffff) stat_wr_d = stat_wr_q + 16'd1;
`endif
        end
      end
      default: state_d = StIdle;
    endcase

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push = ld_wr && (!fifo_full || pop);
    if (push) begin
      fifo_d[wptr_q[IW-1:0]] = {ld_addr, ld_data};
      wptr_d                 = wptr_q + PW'(1);
    end
    if (ld_wr && !push) ovf_d = 1'b1;
    if (pop) rptr_d = rptr_q + PW'(1);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      op_wr_q    <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      lat_q      <= '0;
      starve_q   <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      ovf_q      <= 1'b0;
      cas_data_q <= '0;
      for (int i = 0; i < int'(WFIFO_DEPTH); i++) fifo_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      op_wr_q    <= op_wr_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      lat_q      <= lat_d;
      starve_q   <= starve_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      ovf_q      <= ovf_d;
      cas_data_q <= cas_data_d;
      fifo_q     <= fifo_d;
    end
  end

`ifdef SDRAM_ARB_STATS_EN
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      stat_wr_q     <= '0;
      stat_rd_q     <= '0;
      stat_starve_q <= '0;
    end else begin
      stat_wr_q     <= stat_wr_d;
      stat_rd_q     <= stat_rd_d;
      stat_starve_q <= stat_starve_d;
    end
  end

  assign stat_wr_cnt     = stat_wr_q;
  assign stat_rd_cnt     = stat_rd_q;
  assign stat_starve_cnt = stat_starve_q;
`endif

  assign ld_busy     = !fifo_empty || (state_q != StIdle && op_wr_q);
  assign ld_overflow = ovf_q;
  assign cas_data    = cas_ack ? mem_dout : cas_data_q;
  assign mem_addr    = (state_q != StIdle) ? addr_q : '0;
  assign mem_din     = (state_q != StIdle) ? din_q : '0;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed self-checking bench for sdram_port_arbiter (MEM_LAT=6, depth 4, STARVE_MAX=3).
module tb_sdram_port_arbiter;

  localparam int AW = 25;

  typedef struct packed {
    logic          rd;
    logic [AW-1:0] addr;
    logic [7:0]    din;
  } evt_t;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic          ld_wr, ld_busy, ld_overflow;
  logic [AW-1:0] ld_addr, cas_addr, mem_addr;
  logic [7:0]    ld_data, cas_data, mem_din, mem_dout;
  logic          cas_req, cas_ack, mem_we, mem_rd, mem_ready;
`ifdef SDRAM_ARB_STATS_EN
  logic [15:0]   stat_wr_cnt, stat_rd_cnt;
  logic [7:0]    stat_starve_cnt;
`endif

  int   checks   = 0;
  int   failures = 0;
  int   ack_cnt  = 0;
  evt_t evq[$];

  sdram_port_arbiter #(.AW(AW), .WFIFO_DEPTH(4), .MEM_LAT(6), .STARVE_MAX(3)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .ld_wr       (ld_wr),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .ld_busy     (ld_busy),
    .ld_overflow (ld_overflow),
    .cas_req     (cas_req),
    .cas_addr    (cas_addr),
    .cas_ack     (cas_ack),
    .cas_data    (cas_data),
    .mem_addr    (mem_addr),
    .mem_din     (mem_din),
    .mem_we      (mem_we),
    .mem_rd      (mem_rd),
    .mem_dout    (mem_dout),
    .mem_ready   (mem_ready)
`ifdef SDRAM_ARB_STATS_EN
    ,
    .stat_wr_cnt     (stat_wr_cnt),
    .stat_rd_cnt     (stat_rd_cnt),
    .stat_starve_cnt (stat_starve_cnt)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  // Log every SDRAM command pulse and every ack, mid-cycle.
  always @(negedge clk_sys) begin
    if (mem_we || mem_rd) evq.push_back(evt_t'{mem_rd, mem_addr, mem_din});
    if (cas_ack) ack_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Inputs change 1 time unit after the rising edge; checks happen at +4.
  task automatic next();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; ld_wr = 1'b0; ld_addr = '0; ld_data = '0;
    cas_req = 1'b0; cas_addr = '0; mem_dout = '0; mem_ready = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1;
    reset = 1'b0;
    evq.delete();
    ack_cnt = 0;
  endtask

  // n = 1 in the calling cycle; returns at +4 of the ack cycle, or n = 0 on timeout.
  task automatic wait_ack(input int max, output int n);
    n = 0;
    for (int i = 1; i <= max; i++) begin
      #3;
      if (cas_ack) begin
        n = i;
        return;
      end
      next();
    end
  endtask

  task automatic test_reset();
    do_reset();
    #3;
    checks++; if (cas_ack !== 1'b0) begin failures++; $display("FAIL reset_cas_ack: got %b want 0", cas_ack); end
    checks++; if (cas_data !== 8'h00) begin failures++; $display("FAIL reset_cas_data: got %h want 00", cas_data); end
    checks++; if ({mem_we, mem_rd} !== 2'b00) begin failures++; $display("FAIL reset_mem_cmd: got %b want 00", {mem_we, mem_rd}); end
    checks++; if (mem_addr !== '0) begin failures++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    checks++; if (mem_din !== 8'h00) begin failures++; $display("FAIL reset_mem_din: got %h want 00", mem_din); end
    checks++; if ({ld_busy, ld_overflow} !== 2'b00) begin failures++; $display("FAIL reset_ld_flags: got %b want 00", {ld_busy, ld_overflow}); end
`ifdef SDRAM_ARB_STATS_EN
    checks++; if ({stat_wr_cnt, stat_rd_cnt, stat_starve_cnt} !== 40'd0) begin failures++; $display("FAIL reset_stats: got %h want 0", {stat_wr_cnt, stat_rd_cnt, stat_starve_cnt}); end
`endif
  endtask

  task automatic test_read_latency();
    int n;
    do_reset();
    mem_ready = 1'b1; mem_dout = 8'hA5; cas_addr = 25'h10; cas_req = 1'b1;
    wait_ack(20, n);
    checks++; if (n !== 9) begin failures++; $display("FAIL read_latency: got %0d cycles want 9", n); end
    checks++; if (cas_data !== 8'hA5) begin failures++; $display("FAIL read_data_ack: got %h want a5", cas_data); end
    checks++; if (mem_addr !== 25'h10) begin failures++; $display("FAIL read_addr_done: got %h want 10", mem_addr); end
    next();
    cas_req = 1'b0;
    #3;
    checks++; if (cas_ack !== 1'b0) begin failures++; $display("FAIL read_ack_pulse: got %b want 0", cas_ack); end
    checks++; if (cas_data !== 8'hA5) begin failures++; $display("FAIL read_data_hold: got %h want a5", cas_data); end
    checks++; if (mem_addr !== '0) begin failures++; $display("FAIL read_addr_idle: got %h want 0", mem_addr); end
    checks++;
    if (evq.size() != 1 || evq[0].rd !== 1'b1 || evq[0].addr !== 25'h10) begin
      failures++; $display("FAIL read_cmd_log: got %0d cmds want one read at 10", evq.size());
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ld_wr = 1'b1; ld_addr = AW'(i); ld_data = 8'(8'h11 * (i + 1));
      next();
    end
    ld_wr = 1'b0;
    repeat (32) next();
    #3;
    checks++; if (ld_busy !== 1'b1) begin failures++; $display("FAIL b2b_busy_last_done: got %b want 1", ld_busy); end
    next();
    #3;
    checks++; if (ld_busy !== 1'b0) begin failures++; $display("FAIL b2b_busy_after: got %b want 0", ld_busy); end
    checks++; if (ld_overflow !== 1'b0) begin failures++; $display("FAIL b2b_overflow: got %b want 0", ld_overflow); end
    checks++; if (evq.size() != 4) begin failures++; $display("FAIL b2b_cmd_count: got %0d want 4", evq.size()); end
    for (int i = 0; i < 4 && i < evq.size(); i++) begin
      checks++;
      if (evq[i] !== evt_t'{1'b0, AW'(i), 8'(8'h11 * (i + 1))}) begin
        failures++; $display("FAIL b2b_write_%0d: got %h want %h", i, evq[i], evt_t'{1'b0, AW'(i), 8'(8'h11 * (i + 1))});
      end
    end
`ifdef SDRAM_ARB_STATS_EN
    checks++; if (stat_wr_cnt !== 16'd4) begin failures++; $display("FAIL b2b_stat_wr: got %0d want 4", stat_wr_cnt); end
`endif
  endtask

  task automatic test_starve();
    int   n;
    evt_t exp_q[5];
    exp_q[0] = '{1'b0, 25'h100, 8'hB0};
    exp_q[1] = '{1'b0, 25'h101, 8'hB1};
    exp_q[2] = '{1'b0, 25'h102, 8'hB2};
    exp_q[3] = '{1'b1, 25'h123, 8'h00};
    exp_q[4] = '{1'b0, 25'h103, 8'hB3};
    do_reset();
    mem_ready = 1'b1; mem_dout = 8'h5C; cas_addr = 25'h123;
    for (int i = 0; i < 4; i++) begin
      ld_wr = 1'b1; ld_addr = AW'(25'h100 + i); ld_data = 8'(8'hB0 + i);
      if (i == 1) cas_req = 1'b1;
      next();
    end
    ld_wr = 1'b0;
    wait_ack(40, n);
    checks++; if (n !== 33) begin failures++; $display("FAIL starve_ack_time: got %0d want 33", n); end
    checks++; if (cas_data !== 8'h5C) begin failures++; $display("FAIL starve_ack_data: got %h want 5c", cas_data); end
    checks++; if (evq.size() != 4) begin failures++; $display("FAIL starve_cmds_at_ack: got %0d want 4", evq.size()); end
    next();
    cas_req = 1'b0;
    repeat (12) next();
    #3;
    checks++; if (evq.size() != 5) begin failures++; $display("FAIL starve_cmd_count: got %0d want 5", evq.size()); end
    for (int i = 0; i < 5 && i < evq.size(); i++) begin
      checks++;
      if (evq[i].rd !== exp_q[i].rd || evq[i].addr !== exp_q[i].addr ||
          (!exp_q[i].rd && evq[i].din !== exp_q[i].din)) begin
        failures++; $display("FAIL starve_cmd_%0d: got %h want %h", i, evq[i], exp_q[i]);
      end
    end
`ifdef SDRAM_ARB_STATS_EN
    checks++; if (stat_wr_cnt !== 16'd4) begin failures++; $display("FAIL stat_wr: got %0d want 4", stat_wr_cnt); end
    checks++; if (stat_rd_cnt !== 16'd1) begin failures++; $display("FAIL stat_rd: got %0d want 1", stat_rd_cnt); end
    checks++; if (stat_starve_cnt !== 8'd1) begin failures++; $display("FAIL stat_starve: got %0d want 1", stat_starve_cnt); end
`endif
  endtask

  task automatic test_overflow();
    int   n;
    evt_t exp_q[6];
    exp_q[0] = '{1'b1, 25'h040, 8'h00};
    exp_q[1] = '{1'b0, 25'h200, 8'hC0};
    exp_q[2] = '{1'b0, 25'h201, 8'hC1};
    exp_q[3] = '{1'b0, 25'h202, 8'hC2};
    exp_q[4] = '{1'b0, 25'h203, 8'hC3};
    exp_q[5] = '{1'b0, 25'h2AA, 8'hEE};
    do_reset();
    cas_addr = 25'h40; cas_req = 1'b1; mem_dout = 8'h99;
    next();
    // Read is parked in ISSUE, so nothing drains the FIFO.
    for (int i = 0; i < 5; i++) begin
      ld_wr = 1'b1; ld_addr = AW'(25'h200 + i); ld_data = 8'(8'hC0 + i);
      if (i == 4) begin
        #3;
        checks++; if (ld_overflow !== 1'b0) begin failures++; $display("FAIL ovf_early: got %b want 0", ld_overflow); end
      end
      next();
    end
    ld_wr = 1'b0;
    #3;
    checks++; if (ld_overflow !== 1'b1) begin failures++; $display("FAIL ovf_set: got %b want 1", ld_overflow); end
    checks++; if (ld_busy !== 1'b1) begin failures++; $display("FAIL ovf_busy: got %b want 1", ld_busy); end
    checks++; if (evq.size() != 0) begin failures++; $display("FAIL ovf_no_cmd_unready: got %0d want 0", evq.size()); end
    next();
    mem_ready = 1'b1;
    wait_ack(20, n);
    checks++; if (n !== 8) begin failures++; $display("FAIL ovf_read_time: got %0d want 8", n); end
    checks++; if (cas_data !== 8'h99) begin failures++; $display("FAIL ovf_read_data: got %h want 99", cas_data); end
    next();
    cas_req = 1'b0; ld_wr = 1'b1; ld_addr = 25'h2AA; ld_data = 8'hEE;
    next();
    ld_wr = 1'b0;
    repeat (50) next();
    #3;
    checks++; if (evq.size() != 6) begin failures++; $display("FAIL ovf_cmd_count: got %0d want 6", evq.size()); end
    for (int i = 0; i < 6 && i < evq.size(); i++) begin
      checks++;
      if (evq[i].rd !== exp_q[i].rd || evq[i].addr !== exp_q[i].addr ||
          (!exp_q[i].rd && evq[i].din !== exp_q[i].din)) begin
        failures++; $display("FAIL ovf_cmd_%0d: got %h want %h", i, evq[i], exp_q[i]);
      end
    end
    checks++; if (ld_overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %b want 1", ld_overflow); end
    checks++; if (ld_busy !== 1'b0) begin failures++; $display("FAIL ovf_busy_end: got %b want 0", ld_busy); end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    mem_ready = 1'b1; mem_dout = 8'h3C; cas_addr = 25'h77; cas_req = 1'b1;
    ld_wr = 1'b1; ld_addr = 25'h300; ld_data = 8'h5A;
    next();
    ld_wr = 1'b0;
    repeat (2) next();
    #3;
    checks++; if (ld_busy !== 1'b1) begin failures++; $display("FAIL rmid_busy_before: got %b want 1", ld_busy); end
    next();
    reset = 1'b1;
    #3;
    checks++; if ({mem_we, mem_rd} !== 2'b00) begin failures++; $display("FAIL rmid_mem_cmd: got %b want 00", {mem_we, mem_rd}); end
    checks++; if (ld_busy !== 1'b0) begin failures++; $display("FAIL rmid_busy: got %b want 0", ld_busy); end
    checks++; if (mem_addr !== '0) begin failures++; $display("FAIL rmid_addr: got %h want 0", mem_addr); end
    cas_req = 1'b0;
    repeat (2) next();
    reset = 1'b0;
    repeat (12) next();
    #3;
    checks++; if (ack_cnt !== 0) begin failures++; $display("FAIL rmid_no_ack: got %0d acks want 0", ack_cnt); end
    checks++; if (evq.size() != 1) begin failures++; $display("FAIL rmid_cmd_count: got %0d want 1", evq.size()); end
    next();
    cas_addr = 25'h78; cas_req = 1'b1;
    wait_ack(20, n);
    checks++; if (n !== 9) begin failures++; $display("FAIL rmid_new_read_time: got %0d want 9", n); end
    checks++; if (cas_data !== 8'h3C) begin failures++; $display("FAIL rmid_new_read_data: got %h want 3c", cas_data); end
    checks++; if (mem_addr !== 25'h78) begin failures++; $display("FAIL rmid_new_read_addr: got %h want 78", mem_addr); end
    next();
    cas_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_read_latency();
    test_back_to_back();
    test_starve();
    test_overflow();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
